// File: rtl/pwm_channel_monitor.sv
// pwm_channel_monitor
// Conditions one RC PWM decoder channel: rejects flagged or out-of-range
// pulses, median-of-3 filters accepted pulses, and tracks lock/failsafe.
module pwm_channel_monitor #(
  parameter int          clockFreq      = 50000000,
  parameter logic [15:0] PULSE_MIN      = 16'd900,
  parameter logic [15:0] PULSE_MAX      = 16'd2100,
  parameter int          LOCK_COUNT     = 3,
  parameter int          FAILSAFE_MS    = 100,
  parameter logic [15:0] FAILSAFE_VALUE = 16'd1000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pwm_ready,
  input  logic [15:0] i_pwm_value,
  output logic [15:0] o_value,
  output logic        o_valid,
  output logic        o_failsafe,
  output logic        o_update,
  output logic [7:0]  o_error_count
);

  localparam int          TICK_DIV   = (clockFreq / 1000 > 1) ? clockFreq / 1000 : 1;
  localparam int          PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]  LOCK_N     = 4'(LOCK_COUNT);
  localparam logic [15:0] TIMEOUT_MS = 16'(FAILSAFE_MS);

  typedef enum logic [1:0] {NO_SIGNAL, ACQUIRING, LOCKED} state_t;

  state_t        state, state_next;
  logic          ready_prev;
  logic [PW-1:0] presc;
  logic          tick;
  logic [15:0]   ms_cnt;
  logic [3:0]    good_cnt, good_next;
  logic [3:0]    bad_cnt, bad_next;
  logic [15:0]   value_next;
  logic          update_next;
  logic          clear_hist;
  logic          strobe, in_range, pulse_ok, pulse_bad, timeout;
  logic [15:0]   median;

  // History of accepted pulses, newest first. The third-oldest entry that
  // the shift would produce is never read by the median, so it is not kept.
  logic [15:0]   h0, h1;

  function automatic logic [15:0] median3(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [15:0] c);
    if ((b <= a && a <= c) || (c <= a && a <= b))
      return a;
    else if ((a <= b && b <= c) || (c <= b && b <= a))
      return b;
    else
      return c;
  endfunction

  assign strobe    = i_pwm_ready & ~ready_prev;
  assign in_range  = ~i_pwm_value[15] && (i_pwm_value >= PULSE_MIN) &&
                     (i_pwm_value <= PULSE_MAX);
  assign pulse_ok  = strobe & in_range;
  assign pulse_bad = strobe & ~in_range;
  assign median    = median3(i_pwm_value, h0, h1);
  assign tick      = (presc == TICK_LAST);
  // A valid pulse in the expiry cycle keeps the channel alive.
  assign timeout   = (state != NO_SIGNAL) && (ms_cnt >= TIMEOUT_MS) && !pulse_ok;

  assign o_valid    = (state == LOCKED);
  assign o_failsafe = (state == NO_SIGNAL);

  // Strobe edge detector, 1 ms prescaler and saturating ms-since-valid counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ready_prev <= 1'b0;
      presc      <= '0;
      ms_cnt     <= '0;
    end else begin
      ready_prev <= i_pwm_ready;
      presc      <= tick ? '0 : presc + 1'b1;
      if (pulse_ok)
        ms_cnt <= '0;
      else if (tick && ms_cnt != 16'hFFFF)
        ms_cnt <= ms_cnt + 16'd1;
    end
  end

  // Next-state, lock counters and output value selection
  always_comb begin
    state_next  = state;
    good_next   = good_cnt;
    bad_next    = bad_cnt;
    value_next  = o_value;
    update_next = 1'b0;
    clear_hist  = 1'b0;
    if (timeout) begin
      state_next = NO_SIGNAL;
      good_next  = '0;
      bad_next   = '0;
      value_next = FAILSAFE_VALUE;
      clear_hist = 1'b1;
    end else begin
      case (state)
        NO_SIGNAL: begin
          if (pulse_ok) begin
            state_next = ACQUIRING;
            good_next  = 4'd1;
          end
        end
        ACQUIRING: begin
          if (pulse_ok) begin
            good_next = good_cnt + 4'd1;
            if (good_cnt + 4'd1 == LOCK_N) begin
              state_next  = LOCKED;
              bad_next    = '0;
              value_next  = median;
              update_next = 1'b1;
            end
          end else if (pulse_bad) begin
            good_next = '0;
          end
        end
        LOCKED: begin
          if (pulse_ok) begin
            bad_next    = '0;
            value_next  = median;
            update_next = 1'b1;
          end else if (pulse_bad) begin
            bad_next = bad_cnt + 4'd1;
            if (bad_cnt + 4'd1 == LOCK_N) begin
              state_next = ACQUIRING;
              good_next  = '0;
              bad_next   = '0;
              value_next = FAILSAFE_VALUE;
            end
          end
        end
        default: begin
          state_next = NO_SIGNAL;
          value_next = FAILSAFE_VALUE;
        end
      endcase
    end
  end

  // State register, lock counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= NO_SIGNAL;
      good_cnt <= '0;
      bad_cnt  <= '0;
      o_value  <= FAILSAFE_VALUE;
      o_update <= 1'b0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
      bad_cnt  <= bad_next;
      o_value  <= value_next;
      o_update <= update_next;
    end
  end

  // Pulse history: shift on valid pulses, refill with failsafe on signal loss
  always_ff @(posedge i_clk) begin
    if (i_reset || clear_hist) begin
      h0 <= FAILSAFE_VALUE;
      h1 <= FAILSAFE_VALUE;
    end else if (pulse_ok) begin
      h1 <= h0;
      h0 <= i_pwm_value;
    end
  end

  // Rejected-pulse counter, saturating, counts in every state
  always_ff @(posedge i_clk) begin
    if (i_reset)
      o_error_count <= '0;
    else if (pulse_bad && o_error_count != 8'hFF)
      o_error_count <= o_error_count + 8'd1;
  end

endmodule

// File: tb/tb_pwm_channel_monitor.sv
// Self-checking bench for pwm_channel_monitor: directed vector table,
// timeout / simultaneous / reset sequences, and random strobes vs. a model.
module tb_pwm_channel_monitor;

  localparam int CLK_HZ  = 10000;  // 10 cycles per ms
  localparam int CYC_MS  = 10;
  localparam int FS_MS   = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [15:0] pval;
  logic [15:0] o_value;
  logic        o_valid, o_failsafe, o_update;
  logic [7:0]  o_error_count;

  pwm_channel_monitor #(
    .clockFreq(CLK_HZ), .PULSE_MIN(16'd900), .PULSE_MAX(16'd2100),
    .LOCK_COUNT(3), .FAILSAFE_MS(FS_MS), .FAILSAFE_VALUE(16'd1000)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_pwm_ready(ready), .i_pwm_value(pval),
    .o_value(o_value), .o_valid(o_valid), .o_failsafe(o_failsafe),
    .o_update(o_update), .o_error_count(o_error_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] ev, input logic evld,
                           input logic efs, input logic eupd, input logic [7:0] eerr);
    check({tag, " value"},    o_value,       ev);
    check({tag, " valid"},    o_valid,       evld);
    check({tag, " failsafe"}, o_failsafe,    efs);
    check({tag, " update"},   o_update,      eupd);
    check({tag, " errcnt"},   o_error_count, eerr);
  endtask

  // Raise ready with a value; returns at the negedge after the capturing edge.
  task automatic apply(input logic [15:0] v);
    ready = 1'b1;
    pval  = v;
    @(negedge clk);
  endtask

  // Finish a strobe of 'hold' cycles, check o_update has dropped, then idle.
  task automatic finish(input string tag, input int hold, input int gap);
    if (hold <= 1) ready = 1'b0;
    @(negedge clk);
    check({tag, " update width"}, o_update, 1'b0);
    if (hold >= 2) begin
      repeat (hold - 2) @(negedge clk);
      ready = 1'b0;
    end
    repeat (gap) @(negedge clk);
  endtask

  // ---------------- behavioural reference model (per measurement) ----------
  int          m_mode;   // 0 no signal, 1 acquiring, 2 locked
  int          m_good, m_bad, m_err;
  logic [15:0] m_val;
  logic        m_upd;
  logic [15:0] m_hist[$];  // last accepted pulses, newest at index 0

  function automatic logic [15:0] med(input logic [15:0] a, input logic [15:0] b,
                                      input logic [15:0] c);
    logic [15:0] s[3];
    logic [15:0] t;
    s[0] = a; s[1] = b; s[2] = c;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    return s[1];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_good = 0; m_bad = 0; m_err = 0; m_val = 16'd1000; m_upd = 1'b0;
    m_hist = {16'd1000, 16'd1000};
  endtask

  task automatic model_step(input logic [15:0] v);
    logic [15:0] m;
    bit ok;
    ok = !v[15] && v >= 16'd900 && v <= 16'd2100;
    m_upd = 1'b0;
    if (!ok) begin
      if (m_err < 255) m_err++;
      if (m_mode == 1) m_good = 0;
      else if (m_mode == 2) begin
        m_bad++;
        if (m_bad == 3) begin m_mode = 1; m_good = 0; m_bad = 0; m_val = 16'd1000; end
      end
    end else begin
      m = med(v, m_hist[0], m_hist[1]);
      m_hist.push_front(v);
      m_hist = m_hist[0:1];
      if (m_mode == 0) begin m_mode = 1; m_good = 1; end
      else if (m_mode == 1) begin
        m_good++;
        if (m_good == 3) begin m_mode = 2; m_bad = 0; m_val = m; m_upd = 1'b1; end
      end else begin
        m_bad = 0; m_val = m; m_upd = 1'b1;
      end
    end
  endtask

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    logic [15:0] v;
    int          hold;
    logic [15:0] ev;
    logic        evld, efs, eupd;
    logic [7:0]  eerr;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int sa, sb, t_fs, since_valid;
    logic [15:0] v;
    bit ok;

    // lock on 1500/1510/1490
    tbl[0]  = '{16'd1500, 1, 16'd1000, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{16'd1510, 1, 16'd1000, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{16'd1490, 1, 16'd1500, 1'b1, 1'b0, 1'b1, 8'd0};
    // fill history with 1500s, then spike
    tbl[3]  = '{16'd1500, 1, 16'd1500, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[4]  = '{16'd1500, 3, 16'd1500, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[5]  = '{16'd1500, 1, 16'd1500, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[6]  = '{16'd2000, 1, 16'd1500, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[7]  = '{16'd1500, 1, 16'd1500, 1'b1, 1'b0, 1'b1, 8'd0};
    // invalid pulses drop lock; first one held high 4 cycles
    tbl[8]  = '{16'h8A28, 4, 16'd1500, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[9]  = '{16'd850,  1, 16'd1500, 1'b1, 1'b0, 1'b0, 8'd2};
    tbl[10] = '{16'd2200, 1, 16'd1000, 1'b0, 1'b0, 1'b0, 8'd3};
    // range boundaries
    tbl[11] = '{16'd900,  1, 16'd1000, 1'b0, 1'b0, 1'b0, 8'd3};
    tbl[12] = '{16'd2100, 1, 16'd1000, 1'b0, 1'b0, 1'b0, 8'd3};
    tbl[13] = '{16'd899,  1, 16'd1000, 1'b0, 1'b0, 1'b0, 8'd4};
    tbl[14] = '{16'd2101, 1, 16'd1000, 1'b0, 1'b0, 1'b0, 8'd5};
    tbl[15] = '{16'd900,  1, 16'd1000, 1'b0, 1'b0, 1'b0, 8'd5};
    tbl[16] = '{16'd900,  1, 16'd1000, 1'b0, 1'b0, 1'b0, 8'd5};
    tbl[17] = '{16'd2100, 1, 16'd900,  1'b1, 1'b0, 1'b1, 8'd5};

    rst = 1'b1; ready = 1'b0; pval = 16'd0;
    repeat (2) @(negedge clk);
    check_all("reset", 16'd1000, 1'b0, 1'b1, 1'b0, 8'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].v);
      check_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].evld, tbl[i].efs,
                tbl[i].eupd, tbl[i].eerr);
      finish($sformatf("vec%0d", i), tbl[i].hold, 100);
    end

    // ---- timeout: last valid pulse then silence ----
    apply(16'd1500);
    sa = cyc;
    check_all("pre-timeout", 16'd1500, 1'b1, 1'b0, 1'b1, 8'd5);
    finish("pre-timeout", 1, 0);
    while (!o_failsafe && (cyc - sa) < 3000) @(negedge clk);
    t_fs = cyc - sa;
    check("timeout seen", o_failsafe, 1'b1);
    check("timeout window", (t_fs >= (FS_MS - 1) * CYC_MS && t_fs <= (FS_MS + 1) * CYC_MS + 2), 1'b1);
    check_all("timeout", 16'd1000, 1'b0, 1'b1, 1'b0, 8'd5);
    if (!o_failsafe) t_fs = FS_MS * CYC_MS;

    apply(16'd1500);
    check_all("reacq1", 16'd1000, 1'b0, 1'b0, 1'b0, 8'd5);
    finish("reacq1", 1, 50);
    apply(16'd1500);
    check_all("reacq2", 16'd1000, 1'b0, 1'b0, 1'b0, 8'd5);
    finish("reacq2", 1, 50);
    apply(16'd1500);
    check_all("reacq3", 16'd1500, 1'b1, 1'b0, 1'b1, 8'd5);
    finish("reacq3", 1, 50);

    // ---- valid pulse exactly on the expiry cycle (same prescaler phase) ----
    while (((cyc + 1 - sa) % CYC_MS) != 0) @(negedge clk);
    apply(16'd1600);
    sb = cyc;
    check_all("simul arm", 16'd1500, 1'b1, 1'b0, 1'b1, 8'd5);
    finish("simul arm", 1, 0);
    while (cyc + 1 < sb + t_fs) @(negedge clk);
    apply(16'd1700);
    check_all("simul", 16'd1600, 1'b1, 1'b0, 1'b1, 8'd5);
    finish("simul", 1, 50);
    check("simul still alive", o_failsafe, 1'b0);

    // ---- reset mid-operation with a strobe in the same cycle ----
    check("pre-reset errcnt", o_error_count, 8'd5);
    rst = 1'b1; ready = 1'b1; pval = 16'd1500;
    @(negedge clk);
    check_all("midreset", 16'd1000, 1'b0, 1'b1, 1'b0, 8'd0);
    rst = 1'b0; ready = 1'b0;
    @(negedge clk);

    // ---- randomized strobes against the model ----
    model_reset();
    since_valid = 0;
    for (int k = 0; k < 200; k++) begin
      int r, hold, gap;
      r = $urandom_range(0, 9);
      case (r)
        6:       v = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
        7:       v = 16'($urandom_range(0, 899));
        8:       v = 16'($urandom_range(2101, 16'h7FFF));
        9: begin
          case ($urandom_range(0, 3))
            0: v = 16'd899;
            1: v = 16'd900;
            2: v = 16'd2100;
            default: v = 16'd2101;
          endcase
        end
        default: v = 16'($urandom_range(900, 2100));
      endcase
      if (since_valid > 500) v = 16'($urandom_range(900, 2100));
      ok = !v[15] && v >= 16'd900 && v <= 16'd2100;
      hold = $urandom_range(1, 3);
      gap  = $urandom_range(1, 20);
      model_step(v);
      apply(v);
      check_all($sformatf("rnd%0d", k), m_val, (m_mode == 2), (m_mode == 0),
                m_upd, 8'(m_err));
      finish($sformatf("rnd%0d", k), hold, gap);
      since_valid = ok ? 0 : since_valid + hold + gap + 2;
    end

    // ---- error counter saturation ----
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 260; k++) begin
      ready = 1'b1; pval = 16'd500;
      @(negedge clk);
      ready = 1'b0;
      @(negedge clk);
    end
    check("errcnt saturate", o_error_count, 8'd255);
    check("errcnt sat failsafe", o_failsafe, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
